// File: rtl/rv32i_pkg.sv
// Shared integer-core definitions: register/data widths, writeback request
// bundle and the writeback source encoding used by arbitration.
package rv32i_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

    typedef struct packed {
        logic                  valid;
        reg_idx_t              rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    // Bit position of each source in the one-hot grant matches its encoding.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant from the request pair, with the
// preference pointer toggling on every accepted request.
module wb_rr_arbiter
    import rv32i_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    wb_src_e rr_q;
    wb_src_e rr_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (rr_q == WB_ALU) ? 2'b01 : 2'b10;
        end
    end

    // A grant is always a handshake, since ready is the grant itself.
    always_comb begin
        rr_d = rr_q;
        if (|gnt_o) begin
            rr_d = (rr_q == WB_ALU) ? WB_LSU : WB_ALU;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= WB_ALU;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_controller.sv
// Register-file write-port owner: arbitrates ALU/LSU writebacks onto a single
// registered write port and tracks in-flight destinations for hazard stalls.
module regfile_wb_controller
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  flush,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_rd,
    output logic [DATA_WIDTH-1:0] wr_data
);

    logic [1:0]            gnt;
    logic                  alu_hs;
    logic                  lsu_hs;
    logic                  wb_hs;
    logic                  iss_hs;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;
    logic                  wr_en_q;
    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_rd_q;
    logic [ADDR_WIDTH-1:0] wr_rd_d;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] wr_data_d;

    wb_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({lsu_valid, alu_valid}),
        .gnt_o (gnt)
    );

    assign alu_ready = gnt[0];
    assign lsu_ready = gnt[1];
    assign alu_hs    = alu_valid & alu_ready;
    assign lsu_hs    = lsu_valid & lsu_ready;
    assign wb_hs     = alu_hs | lsu_hs;
    assign wb_rd     = lsu_hs ? lsu_rd   : alu_rd;
    assign wb_data   = lsu_hs ? lsu_data : alu_data;

    // No bypass: a clear landing this edge does not release issue until next cycle.
    assign iss_ready = !pending_q[iss_rd] || (iss_rd == '0);
    assign iss_hs    = iss_valid && iss_ready && (iss_rd != '0);
    assign rs1_busy  = pending_q[rs1] && (rs1 != '0);
    assign rs2_busy  = pending_q[rs2] && (rs2 != '0);

    always_comb begin
        wr_en_d   = 1'b0;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        pending_d = pending_q;
        if (wb_hs) begin
            wr_en_d   = (wb_rd != '0);
            wr_rd_d   = wb_rd;
            wr_data_d = wb_data;
            pending_d[wb_rd] = 1'b0;
        end
        // Set after clear so a same-edge set of the same register wins; flush beats both.
        if (iss_hs) begin
            pending_d[iss_rd] = 1'b1;
        end
        if (flush) begin
            pending_d = '0;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_rd   = wr_rd_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_controller.sv
// Directed bench for regfile_wb_controller with a reference model of the
// arbiter pointer and pending table, and a write scoreboard.
module tb_regfile_wb_controller;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_exp_t;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        flush;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;

    int          checks = 0;
    int          errors = 0;
    wr_exp_t     exp_q[$];
    logic        rr_m;
    logic [31:0] pend_m;

    regfile_wb_controller #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .NUM_REGS   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_rd     (wr_rd),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every queued write must appear on the cycle right after its handshake.
    always @(negedge clk) begin
        wr_exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_wr_en", {31'd0, wr_en}, 32'd1);
            chk("sb_wr_rd", {27'd0, wr_rd}, {27'd0, e.rd});
            chk("sb_wr_data", wr_data, e.data);
        end else begin
            chk("sb_idle_wr_en", {31'd0, wr_en}, 32'd0);
        end
    end

    task automatic model_reset();
        rr_m   = 1'b0;
        pend_m = '0;
        exp_q.delete();
    endtask

    // One clock: check combinational outputs against the model, then advance it.
    task automatic step();
        logic ea, el, ei;
        wr_exp_t e;
        @(negedge clk);
        ea = alu_valid && (!lsu_valid || rr_m == 1'b0);
        el = lsu_valid && (!alu_valid || rr_m == 1'b1);
        ei = !pend_m[iss_rd] || (iss_rd == 5'd0);
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, ea});
        chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, el});
        chk("iss_ready", {31'd0, iss_ready}, {31'd0, ei});
        chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, pend_m[rs1] && rs1 != 5'd0});
        chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, pend_m[rs2] && rs2 != 5'd0});
        @(posedge clk);
        if (ea && alu_rd != 5'd0) begin
            e.rd = alu_rd; e.data = alu_data; exp_q.push_back(e);
            pend_m[alu_rd] = 1'b0;
        end
        if (el && lsu_rd != 5'd0) begin
            e.rd = lsu_rd; e.data = lsu_data; exp_q.push_back(e);
            pend_m[lsu_rd] = 1'b0;
        end
        if (ea || el) rr_m = ~rr_m;
        if (iss_valid && ei && iss_rd != 5'd0) pend_m[iss_rd] = 1'b1;
        if (flush) pend_m = '0;
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        rs1 = '0; rs2 = '0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_rd", {27'd0, wr_rd}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        rst = 1'b1;

        // ALU-only write after reset
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        chk("t1_wr_en", {31'd0, wr_en}, 32'd1);
        chk("t1_wr_rd", {27'd0, wr_rd}, 32'd5);
        chk("t1_wr_data", wr_data, 32'hDEADBEEF);
        step();
        chk("t1_wr_en_drop", {31'd0, wr_en}, 32'd0);

        // x0 write from LSU: accepted, no write, pointer returns to ALU preference
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFFFFFF;
        rs1 = 5'd0;
        step();
        lsu_valid = 1'b0;
        chk("x0_wr_en", {31'd0, wr_en}, 32'd0);
        chk("x0_rs1_busy", {31'd0, rs1_busy}, 32'd0);

        // Contention from rr=0: ALU, LSU, ALU
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        step();
        chk("ct_first_rd", {27'd0, wr_rd}, 32'd3);
        step();
        chk("ct_second_rd", {27'd0, wr_rd}, 32'd4);
        chk("ct_second_data", wr_data, 32'h22);
        step();
        chk("ct_third_rd", {27'd0, wr_rd}, 32'd3);
        alu_valid = 1'b0; lsu_valid = 1'b0;

        // Scoreboard: issue 7, observe stall, write back 7
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        rs1 = 5'd7;
        #1;
        chk("sb7_rs1_busy", {31'd0, rs1_busy}, 32'd1);
        chk("sb7_iss_ready", {31'd0, iss_ready}, 32'd0);
        step();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        step();
        alu_valid = 1'b0;
        chk("sb7_clear", {31'd0, rs1_busy}, 32'd0);

        // Same-edge set and clear of reg 9: set wins
        iss_valid = 1'b1; iss_rd = 5'd9;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        step();
        iss_valid = 1'b0; lsu_valid = 1'b0;
        rs2 = 5'd9;
        #1;
        chk("setclr_rs2_busy", {31'd0, rs2_busy}, 32'd1);

        // Flush: pending on 1,2,3 cleared, same-edge issue dropped, write kept
        for (int r = 1; r <= 3; r++) begin
            iss_valid = 1'b1; iss_rd = r[4:0];
            step();
        end
        rs1 = 5'd1; rs2 = 5'd3;
        #1;
        chk("fl_pre_rs1", {31'd0, rs1_busy}, 32'd1);
        chk("fl_pre_rs2", {31'd0, rs2_busy}, 32'd1);
        iss_rd = 5'd10; flush = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0FFEE;
        step();
        flush = 1'b0; iss_valid = 1'b0; alu_valid = 1'b0;
        chk("fl_wr_en", {31'd0, wr_en}, 32'd1);
        chk("fl_wr_rd", {27'd0, wr_rd}, 32'd12);
        for (int r = 1; r <= 10; r++) begin
            rs1 = r[4:0];
            #1;
            chk("fl_busy", {31'd0, rs1_busy}, 32'd0);
        end
        rs1 = 5'd0; rs2 = 5'd0;

        // Asynchronous reset while a write is visible
        iss_valid = 1'b1; iss_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        step();
        iss_valid = 1'b0; alu_valid = 1'b0;
        chk("ar_pre_wr_en", {31'd0, wr_en}, 32'd1);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("ar_wr_en", {31'd0, wr_en}, 32'd0);
        chk("ar_wr_rd", {27'd0, wr_rd}, 32'd0);
        chk("ar_wr_data", wr_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rs2 = 5'd9;
        #1;
        chk("ar_pend_clear", {31'd0, rs2_busy}, 32'd0);

        // Pointer back at ALU preference after reset
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA5A5A5A5;
        lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_data = 32'h5A5A5A5A;
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("ar_rr_alu", {27'd0, wr_rd}, 32'd20);
        step();
        step();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
